masked_rand_source: RTL and testbench
=====================================

// Module: masked_rand_source
// PURPOSE
// - Fresh-randomness source for the masked HPC1 multipliers in the S-box datapath.
// - Per handshake it delivers:
//   - a refresh mask out_r: an additive sharing of zero, wired to the multiplier in_r;
//   - pairwise masks out_p, wired to the multiplier in_p.
// - Holds a 64-bit Galois LFSR that is seeded over a 32-bit word port, then warmed up before output is declared valid.
// PARAMETERS
// - NUM_SHARES      2   share count of the consuming multiplier (>=2)
// - BIT_WIDTH       1   bits per share of the consuming multiplier
// - WARMUP_CYCLES   16  LFSR advances after seeding before out_valid rises (>=1)
// - Derived:
//   - NUM_QUADRATIC = NUM_SHARES*(NUM_SHARES-1)/2
//   - OUT_BITS = (NUM_SHARES-1+NUM_QUADRATIC)*BIT_WIDTH; elaboration error if OUT_BITS>64
// PORTS
// - in_clock       in   1                          single clock, rising edge
// - in_reset       in   1                          asynchronous, active-high reset
// - in_seed        in   32                         seed word
// - in_seed_valid  in   1                          in_seed is presented this cycle
// - out_seed_ready out  1                          a seed word is accepted this cycle
// - out_r          out  NUM_SHARES*BIT_WIDTH       zero-sharing refresh mask
// - out_p          out  NUM_QUADRATIC*BIT_WIDTH    pairwise masks, qindex order
// - out_valid      out  1                          out_r/out_p are usable
// - in_ready       in   1                          consumer takes the current masks
// BEHAVIOUR
// - LFSR polynomial: x^64+x^63+x^61+x^60+1, Galois form, one step shifts left and the
//   emitted bit is the old state[63].
// - Mask word: the OUT_BITS bits emitted by OUT_BITS unrolled steps from the current state.
//   Unroll is combinational.
//   - out_p: bits [NUM_QUADRATIC*BIT_WIDTH-1:0].
//   - out_r shares 0..NUM_SHARES-2: the next bits, in order.
//   - out_r share NUM_SHARES-1: XOR of shares 0..NUM_SHARES-2, so the XOR of all out_r shares is always 0.
// - State machine:
//   - UNSEEDED: out_seed_ready=1; a cycle with in_seed_valid latches state[63:32] and moves to SEED_LO.
//   - SEED_LO: out_seed_ready=1; a cycle with in_seed_valid latches state[31:0] and moves to WARMUP.
//     If the assembled 64-bit value is 0, state is forced to 64'h1 (the LFSR must never hold zero).
//   - WARMUP: counter runs WARMUP_CYCLES-1..0, state advances OUT_BITS steps per cycle.
//     Moves to RUN when the counter is 0.
//   - RUN: out_valid=1.
//     - Fire (in_ready=1): state advances OUT_BITS steps on the same edge.
//     - No fire: state, out_r and out_p stay bit-stable.
// - out_r and out_p are masked with out_valid: all-zero whenever out_valid=0.
// - Reset values (asynchronous, immediate): state=0, FSM=UNSEEDED, counter=WARMUP_CYCLES-1.
//   Resulting outputs: out_valid=0, out_seed_ready=1, out_r=0, out_p=0.
// - Reset asserted mid-seed or mid-warmup discards the partial seed. Reseeding from UNSEEDED is required.
// - in_ready outside RUN is ignored.
// - in_seed_valid in WARMUP is ignored.
// - Latency:
//   - reset release to first out_valid: at least 2 seed cycles + WARMUP_CYCLES;
//   - fire to next word: 1 cycle, with full throughput.
// CONFIGURATION
// - MASKED_RAND_SOURCE_RESEED_EN defined:
//   - in RUN, out_seed_ready=1;
//   - in_seed_valid drops out_valid on the next edge and latches state[63:32] as in UNSEEDED.
//     If in_ready=1 on that same edge, the fire is discarded;
//   - flow then continues SEED_LO -> WARMUP -> RUN.
// - Undefined: in RUN, out_seed_ready=0 and in_seed_valid is ignored. Only in_reset reseeds.
// TESTING
// - Reset:
//   - stimulus: in_reset=1, toggle all inputs;
//   - response: out_valid=0, out_r=0, out_p=0, out_seed_ready=1 throughout.
// - Seed and warmup:
//   - stimulus: seed 32'hDEADBEEF then 32'h01234567 on consecutive cycles;
//   - response: out_valid rises exactly WARMUP_CYCLES cycles after the second word;
//     masks equal the C reference model seeded 64'hDEADBEEF01234567.
// - Zero seed:
//   - stimulus: seed 0, 0;
//   - response: state forced to 64'h1; stream matches the model seeded 64'h1, never stuck at zero.
// - Stall:
//   - stimulus: in_ready=0 for 5 cycles in RUN;
//   - response: out_r/out_p unchanged for 5 cycles; next fire yields the model's next word.
// - Zero-sharing check (NUM_SHARES=3, BIT_WIDTH=8, 1000 fires):
//   - response: XOR of out_r shares == 8'h00 every cycle; out_p width is 24.
// - Reset mid-warmup, and reseed in RUN:
//   - reset mid-warmup -> UNSEEDED, out_valid=0;
//   - in RUN with RESEED_EN, in_seed_valid -> out_valid=0 next cycle, new stream after warmup;
//   - without RESEED_EN the same in_seed_valid is ignored and out_valid stays 1.

Source files
------------

// File: rtl/masked_rand_source.sv
// Fresh-randomness source for masked HPC1 multipliers: seeded 64-bit Galois LFSR, unrolled per word.
// Define MASKED_RAND_SOURCE_RESEED_EN to accept a new seed while in RUN.
module masked_rand_source #(
   parameter int NUM_SHARES    = 2,
   parameter int BIT_WIDTH     = 1,
   parameter int WARMUP_CYCLES = 16
) (
   input  logic                                              in_clock,
   input  logic                                              in_reset,
   input  logic [31:0]                                       in_seed,
   input  logic                                              in_seed_valid,
   output logic                                              out_seed_ready,
   output logic [NUM_SHARES*BIT_WIDTH-1:0]                   out_r,
   output logic [NUM_SHARES*(NUM_SHARES-1)/2*BIT_WIDTH-1:0]  out_p,
   output logic                                              out_valid,
   input  logic                                              in_ready
);

   localparam int NUM_QUADRATIC = NUM_SHARES * (NUM_SHARES - 1) / 2;
   localparam int P_BITS        = NUM_QUADRATIC * BIT_WIDTH;
   localparam int OUT_BITS      = (NUM_SHARES - 1 + NUM_QUADRATIC) * BIT_WIDTH;
   localparam int CNT_W         = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WARMUP_CYCLES - 1);
   // Feedback taps for x^64+x^63+x^61+x^60+1 in left-shifting Galois form
   localparam logic [63:0] TAPS = 64'hB000_0000_0000_0001;

`ifdef MASKED_RAND_SOURCE_RESEED_EN
   localparam logic RUN_SEED_READY = 1'b1;
`else
   localparam logic RUN_SEED_READY = 1'b0;
`endif

   if (OUT_BITS > 64 || NUM_SHARES < 2 || WARMUP_CYCLES < 1) begin : g_bad_cfg
      $error("masked_rand_source: invalid configuration (OUT_BITS=%0d)", OUT_BITS);
   end

   typedef enum logic [1:0] {StUnseeded, StSeedLo, StWarmup, StRun} fsm_e;

   fsm_e             fsm;
   logic [63:0]      lfsr;
   logic [63:0]      lfsr_adv;
   logic [63:0]      step;
   logic [63:0]      seed_full;
   logic [CNT_W-1:0] cnt;
   logic             valid_q;
   logic             seed_ready_q;
   logic [OUT_BITS-1:0]              word;
   logic [NUM_SHARES*BIT_WIDTH-1:0]  r_vec;
   logic [BIT_WIDTH-1:0]             r_last;

   // Bit i of the word is the bit emitted by the i-th step from the current state.
   always_comb begin
      step = lfsr;
      word = '0;
      for (int i = 0; i < OUT_BITS; i++) begin
         word[i] = step[63];
         step    = {step[62:0], 1'b0} ^ (step[63] ? TAPS : 64'h0);
      end
      lfsr_adv = step;
   end

   // Last share closes the sharing so all shares XOR to zero.
   always_comb begin
      r_vec  = '0;
      r_last = '0;
      for (int k = 0; k < NUM_SHARES - 1; k++) begin
         r_vec[k*BIT_WIDTH +: BIT_WIDTH] = word[P_BITS + k*BIT_WIDTH +: BIT_WIDTH];
         r_last = r_last ^ word[P_BITS + k*BIT_WIDTH +: BIT_WIDTH];
      end
      r_vec[(NUM_SHARES-1)*BIT_WIDTH +: BIT_WIDTH] = r_last;
   end

   assign seed_full = {lfsr[63:32], in_seed};

   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         fsm          <= StUnseeded;
         lfsr         <= '0;
         cnt          <= CNT_INIT;
         valid_q      <= 1'b0;
         seed_ready_q <= 1'b1;
      end else begin
         unique case (fsm)
            StUnseeded: begin
               if (in_seed_valid) begin
                  lfsr[63:32] <= in_seed;
                  fsm         <= StSeedLo;
               end
            end
            StSeedLo: begin
               if (in_seed_valid) begin
                  lfsr         <= (seed_full == 64'h0) ? 64'h1 : seed_full;
                  cnt          <= CNT_INIT;
                  fsm          <= StWarmup;
                  seed_ready_q <= 1'b0;
               end
            end
            StWarmup: begin
               lfsr <= lfsr_adv;
               if (cnt == '0) begin
                  fsm          <= StRun;
                  valid_q      <= 1'b1;
                  seed_ready_q <= RUN_SEED_READY;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            StRun: begin
`ifdef MASKED_RAND_SOURCE_RESEED_EN
               // A reseed wins over a simultaneous fire
               if (in_seed_valid) begin
                  lfsr[63:32]  <= in_seed;
                  fsm          <= StSeedLo;
                  valid_q      <= 1'b0;
                  seed_ready_q <= 1'b1;
               end else if (in_ready) begin
                  lfsr <= lfsr_adv;
               end
`else
               if (in_ready) begin
                  lfsr <= lfsr_adv;
               end
`endif
            end
            default: fsm <= StUnseeded;
         endcase
      end
   end

   assign out_valid      = valid_q;
   assign out_seed_ready = seed_ready_q;
   assign out_r          = valid_q ? r_vec : '0;
   assign out_p          = valid_q ? word[P_BITS-1:0] : '0;

endmodule

// File: tb/tb_masked_rand_source.sv
// Randomized self-checking bench for masked_rand_source (NUM_SHARES=3, BIT_WIDTH=8).
// Expectations follow MASKED_RAND_SOURCE_RESEED_EN when the macro is defined.
module tb_masked_rand_source;

   localparam int NS = 3;
   localparam int BW = 8;
   localparam int WU = 16;
   localparam int NQ = NS * (NS - 1) / 2;
   localparam int OB = (NS - 1 + NQ) * BW;

`ifdef MASKED_RAND_SOURCE_RESEED_EN
   localparam logic RESEED = 1'b1;
`else
   localparam logic RESEED = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      seed;
   logic             seed_valid;
   logic             seed_ready;
   logic [NS*BW-1:0] out_r;
   logic [NQ*BW-1:0] out_p;
   logic             valid;
   logic             ready;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] m;

   always #5 clk = ~clk;

   masked_rand_source #(
      .NUM_SHARES   (NS),
      .BIT_WIDTH    (BW),
      .WARMUP_CYCLES(WU)
   ) dut (
      .in_clock      (clk),
      .in_reset      (rst),
      .in_seed       (seed),
      .in_seed_valid (seed_valid),
      .out_seed_ready(seed_ready),
      .out_r         (out_r),
      .out_p         (out_p),
      .out_valid     (valid),
      .in_ready      (ready)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One LFSR shift; the emitted bit is the old msb.
   function automatic logic [63:0] lfsr_step(input logic [63:0] s);
      return s[63] ? ((s << 1) ^ 64'hB000_0000_0000_0001) : (s << 1);
   endfunction

   function automatic logic [OB-1:0] model_word(input logic [63:0] s);
      logic [63:0]   t;
      logic [OB-1:0] w;
      t = s;
      w = '0;
      for (int i = 0; i < OB; i++) begin
         w[i] = t[63];
         t    = lfsr_step(t);
      end
      return w;
   endfunction

   function automatic logic [63:0] model_adv(input logic [63:0] s);
      logic [63:0] t;
      t = s;
      for (int i = 0; i < OB; i++) t = lfsr_step(t);
      return t;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, 64'(valid), 64'd0);
      check({tag, "_r"}, 64'(out_r), 64'd0);
      check({tag, "_p"}, 64'(out_p), 64'd0);
      check({tag, "_seed_rdy"}, 64'(seed_ready), 64'd1);
   endtask

   task automatic check_outputs(input string tag);
      logic [OB-1:0]    w;
      logic [NS*BW-1:0] er;
      logic [BW-1:0]    acc;
      logic [BW-1:0]    dut_xor;
      w   = model_word(m);
      er  = '0;
      acc = '0;
      for (int k = 0; k < NS - 1; k++) begin
         er[k*BW +: BW] = w[NQ*BW + k*BW +: BW];
         acc            = acc ^ w[NQ*BW + k*BW +: BW];
      end
      er[(NS-1)*BW +: BW] = acc;
      dut_xor = '0;
      for (int k = 0; k < NS; k++) dut_xor = dut_xor ^ out_r[k*BW +: BW];
      check({tag, "_valid"}, 64'(valid), 64'd1);
      check({tag, "_p"}, 64'(out_p), 64'(w[NQ*BW-1:0]));
      check({tag, "_r"}, 64'(out_r), 64'(er));
      check({tag, "_zero_sharing"}, 64'(dut_xor), 64'd0);
      check({tag, "_seed_rdy"}, 64'(seed_ready), 64'(RESEED));
   endtask

   // Called at a negedge with the DUT ready for the upper seed word.
   task automatic do_seed(input logic [31:0] hi, input logic [31:0] lo);
      int cyc;
      check("seed_rdy_hi", 64'(seed_ready), 64'd1);
      seed_valid = 1'b1;
      seed       = hi;
      ready      = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("seed_rdy_lo", 64'(seed_ready), 64'd1);
      check("valid_seed_lo", 64'(valid), 64'd0);
      seed = lo;
      @(negedge clk);
      m   = ({hi, lo} == 64'h0) ? 64'h1 : {hi, lo};
      cyc = 0;
      while (!valid && cyc < 3 * WU) begin
         if (cyc > 0) check("warmup_seed_rdy", 64'(seed_ready), 64'd0);
         seed_valid = 1'($urandom_range(0, 1));
         seed       = $urandom;
         ready      = 1'($urandom_range(0, 1));
         @(negedge clk);
         cyc++;
      end
      seed_valid = 1'b0;
      ready      = 1'b0;
      check("warmup_len", 64'(cyc), 64'(WU));
      for (int i = 0; i < WU; i++) m = model_adv(m);
   endtask

   task automatic run_random(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         check_outputs(tag);
         ready = ($urandom_range(0, 3) != 0);
         if (ready) m = model_adv(m);
         @(negedge clk);
      end
      ready = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      seed       = $urandom;
      seed_valid = 1'b1;
      ready      = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_idle("reset");
         seed       = $urandom;
         seed_valid = 1'($urandom_range(0, 1));
         ready      = 1'($urandom_range(0, 1));
      end
      rst        = 1'b0;
      seed_valid = 1'b0;
      ready      = 1'b0;
      @(negedge clk);
      check_idle("unseeded");

      do_seed(32'hDEADBEEF, 32'h01234567);
      run_random("run_deadbeef", 50);

      // Stall: word must hold, then the next fire yields the following word.
      for (int i = 0; i < 5; i++) begin
         check_outputs("stall");
         @(negedge clk);
      end
      ready = 1'b1;
      m     = model_adv(m);
      @(negedge clk);
      ready = 1'b0;
      check_outputs("after_stall");

      run_random("run_long", 1300);

      // Seed word presented in RUN together with a fire.
`ifdef MASKED_RAND_SOURCE_RESEED_EN
      do_seed(32'hCAFEF00D, 32'h13579BDF);
`else
      seed_valid = 1'b1;
      seed       = 32'hCAFEF00D;
      ready      = 1'b1;
      m          = model_adv(m);
      @(negedge clk);
      seed_valid = 1'b0;
      ready      = 1'b0;
      check_outputs("ignored_reseed");
`endif
      run_random("run_after_reseed", 30);

      // Reset in the middle of warmup.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      seed_valid = 1'b1;
      seed       = 32'h0BADF00D;
      @(negedge clk);
      seed = 32'h76543210;
      @(negedge clk);
      seed_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check_idle("async_reset");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_idle("after_mid_reset");
      end
      ready = 1'b0;

      do_seed(32'h0, 32'h0);
      run_random("run_zero_seed", 100);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
